// File: rtl/sa_attention_engine_if.sv
// Handshake/bus bundle for sa_attention_engine: input burst (valid, token count,
// token data, three weight streams) and the 64-bit result stream.
interface sa_attention_engine_if;
    logic               in_valid;
    logic [3:0]         T;
    logic signed [7:0]  in_data;
    logic signed [7:0]  w_Q;
    logic signed [7:0]  w_K;
    logic signed [7:0]  w_V;
    logic               out_valid;
    logic signed [63:0] out_data;

    modport master (
        output in_valid, T, in_data, w_Q, w_K, w_V,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, T, in_data, w_Q, w_K, w_V,
        output out_valid, out_data
    );
endinterface

// File: rtl/sa_attention_engine.sv
// sa_attention_engine: single-head integer self-attention,
// Out = ReLU(Q*K^T)/3 * V with Q/K/V = X*W_Q/W_K/W_V, streamed row-major.
// Optional macro SA_CG_EN adds a cg_en port and one clock-gating cell per
// register bank (X, W_Q, W_K, W_V, Q, K, V, S'); outputs are unchanged by it.

`ifdef SA_CG_EN
// Latch-based clock gate: enable is captured while clk is low.
module sa_cg_cell (
    input  logic clk_i,
    input  logic en_i,
    output logic gclk_o
);
    logic en_l;

    // transparent-low enable latch
    always_latch begin
        if (!clk_i) en_l <= en_i;
    end

    assign gclk_o = clk_i & en_l;
endmodule
`endif

module sa_attention_engine (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef SA_CG_EN
    input  logic                 cg_en,
`endif
    sa_attention_engine_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PROJ, S_SCORE, S_OUT} state_e;

    state_e             state_q;
    logic [7:0]         cnt_q;
    logic [3:0]         t_q;
    logic [1:0]         mat_q;
    logic [2:0]         i_q;
    logic [2:0]         j_q;
    logic               out_valid_q;
    logic signed [63:0] out_data_q;

    logic signed [7:0]  x_q  [64];
    logic signed [7:0]  wq_q [64];
    logic signed [7:0]  wk_q [64];
    logic signed [7:0]  wv_q [64];
    logic signed [18:0] q_q  [64];
    logic signed [18:0] k_q  [64];
    logic signed [18:0] v_q  [64];
    logic signed [39:0] s_q  [64];

    logic               ld_act;
    logic [7:0]         ld_idx;
    logic [3:0]         ld_t;
    logic [2:0]         t_last;
    logic signed [7:0]  wsel;
    logic signed [18:0] proj_sum;
    logic signed [39:0] sc_sum;
    logic signed [39:0] sc_div;
    logic signed [56:0] o_sum;

    logic clk_x, clk_wq, clk_wk, clk_wv, clk_q, clk_k, clk_v, clk_s;

    assign t_last = 3'(t_q - 4'd1);

    // Burst cycle 0 is consumed in IDLE, so the load path sees index 0 there
    // and the live counter (starting at 1) during LOAD.
    always_comb begin
        ld_act = (state_q == S_IDLE && bus.in_valid) || (state_q == S_LOAD);
        ld_idx = (state_q == S_LOAD) ? cnt_q : '0;
        ld_t   = (state_q == S_LOAD) ? t_q : bus.T;
    end

`ifdef SA_CG_EN
    logic en_ld, en_q, en_k, en_v, en_s;
    assign en_ld = !cg_en || !rst_n || ld_act;
    assign en_q  = !cg_en || !rst_n || (state_q == S_PROJ && mat_q == 2'd0);
    assign en_k  = !cg_en || !rst_n || (state_q == S_PROJ && mat_q == 2'd1);
    assign en_v  = !cg_en || !rst_n || (state_q == S_PROJ && mat_q == 2'd2);
    assign en_s  = !cg_en || !rst_n || (state_q == S_SCORE);

    sa_cg_cell u_cg_x  (.clk_i(clk), .en_i(en_ld), .gclk_o(clk_x));
    sa_cg_cell u_cg_wq (.clk_i(clk), .en_i(en_ld), .gclk_o(clk_wq));
    sa_cg_cell u_cg_wk (.clk_i(clk), .en_i(en_ld), .gclk_o(clk_wk));
    sa_cg_cell u_cg_wv (.clk_i(clk), .en_i(en_ld), .gclk_o(clk_wv));
    sa_cg_cell u_cg_q  (.clk_i(clk), .en_i(en_q),  .gclk_o(clk_q));
    sa_cg_cell u_cg_k  (.clk_i(clk), .en_i(en_k),  .gclk_o(clk_k));
    sa_cg_cell u_cg_v  (.clk_i(clk), .en_i(en_v),  .gclk_o(clk_v));
    sa_cg_cell u_cg_s  (.clk_i(clk), .en_i(en_s),  .gclk_o(clk_s));
`else
    assign clk_x  = clk;
    assign clk_wq = clk;
    assign clk_wk = clk;
    assign clk_wv = clk;
    assign clk_q  = clk;
    assign clk_k  = clk;
    assign clk_v  = clk;
    assign clk_s  = clk;
`endif

    // X bank: only the first 8T burst cycles carry tokens
    always_ff @(posedge clk_x) begin
        if (rst_n && ld_act && (ld_idx < 8'({ld_t, 3'b000})))
            x_q[ld_idx[5:0]] <= bus.in_data;
    end

    // W_Q bank: burst cycles 0..63
    always_ff @(posedge clk_wq) begin
        if (rst_n && ld_act && ld_idx[7:6] == 2'd0)
            wq_q[ld_idx[5:0]] <= bus.w_Q;
    end

    // W_K bank: burst cycles 64..127
    always_ff @(posedge clk_wk) begin
        if (rst_n && ld_act && ld_idx[7:6] == 2'd1)
            wk_q[ld_idx[5:0]] <= bus.w_K;
    end

    // W_V bank: burst cycles 128..191
    always_ff @(posedge clk_wv) begin
        if (rst_n && ld_act && ld_idx[7:6] == 2'd2)
            wv_q[ld_idx[5:0]] <= bus.w_V;
    end

    // projection element (row i_q, column j_q) of the matrix selected by mat_q
    always_comb begin
        wsel     = '0;
        proj_sum = '0;
        for (int unsigned m = 0; m < 8; m++) begin
            unique case (mat_q)
                2'd0:    wsel = wq_q[{3'(m), j_q}];
                2'd1:    wsel = wk_q[{3'(m), j_q}];
                default: wsel = wv_q[{3'(m), j_q}];
            endcase
            proj_sum = proj_sum + 19'(x_q[{i_q, 3'(m)}]) * 19'(wsel);
        end
    end

    // score S[i_q][j_q] with ReLU and truncating divide by 3
    always_comb begin
        sc_sum = '0;
        for (int unsigned m = 0; m < 8; m++)
            sc_sum = sc_sum + 40'(q_q[{i_q, 3'(m)}]) * 40'(k_q[{j_q, 3'(m)}]);
        sc_div = (sc_sum > 40'sd0) ? (sc_sum / 40'sd3) : '0;
    end

    // output element Out[i_q][j_q]; terms k >= T are muxed out, not multiplied
    always_comb begin
        o_sum = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < 32'(t_q))
                o_sum = o_sum + 57'(s_q[{i_q, 3'(k)}]) * 57'(v_q[{3'(k), j_q}]);
        end
    end

    // Q bank written during the first projection pass
    always_ff @(posedge clk_q) begin
        if (rst_n && state_q == S_PROJ && mat_q == 2'd0) q_q[{i_q, j_q}] <= proj_sum;
    end

    // K bank written during the second projection pass
    always_ff @(posedge clk_k) begin
        if (rst_n && state_q == S_PROJ && mat_q == 2'd1) k_q[{i_q, j_q}] <= proj_sum;
    end

    // V bank written during the third projection pass
    always_ff @(posedge clk_v) begin
        if (rst_n && state_q == S_PROJ && mat_q == 2'd2) v_q[{i_q, j_q}] <= proj_sum;
    end

    // S' bank written during SCORE
    always_ff @(posedge clk_s) begin
        if (rst_n && state_q == S_SCORE) s_q[{i_q, j_q}] <= sc_div;
    end

    // control FSM, sequencing counters and registered output beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            t_q         <= '0;
            mat_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    mat_q <= '0;
                    i_q   <= '0;
                    j_q   <= '0;
                    if (bus.in_valid) begin
                        t_q     <= bus.T;
                        cnt_q   <= 8'd1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == 8'd191) begin
                        cnt_q   <= '0;
                        state_q <= S_PROJ;
                    end
                end
                S_PROJ: begin
                    j_q <= j_q + 3'd1;
                    if (j_q == 3'd7) begin
                        if (i_q == t_last) begin
                            i_q <= '0;
                            if (mat_q == 2'd2) begin
                                mat_q   <= '0;
                                state_q <= S_SCORE;
                            end else begin
                                mat_q <= mat_q + 2'd1;
                            end
                        end else begin
                            i_q <= i_q + 3'd1;
                        end
                    end
                end
                S_SCORE: begin
                    if (j_q == t_last) begin
                        j_q <= '0;
                        if (i_q == t_last) begin
                            i_q     <= '0;
                            state_q <= S_OUT;
                        end else begin
                            i_q <= i_q + 3'd1;
                        end
                    end else begin
                        j_q <= j_q + 3'd1;
                    end
                end
                S_OUT: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= 64'(o_sum);
                    j_q         <= j_q + 3'd1;
                    if (j_q == 3'd7) begin
                        if (i_q == t_last) begin
                            i_q     <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            i_q <= i_q + 3'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_sa_attention_engine.sv
// Directed bench for sa_attention_engine: hand-computed vectors plus a
// behavioural matrix model for the random-valued transactions.
`timescale 1ns/1ps
module tb_sa_attention_engine;
    logic clk = 1'b0;
    logic rst_n;
`ifdef SA_CG_EN
    logic cg_en = 1'b1;
`endif

    always #5 clk = ~clk;

    sa_attention_engine_if bus ();

    sa_attention_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SA_CG_EN
        .cg_en (cg_en),
`endif
        .bus   (bus.slave)
    );

    int     n_chk = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     overlap = 0;
    int     in_end_cyc = 0;
    longint beat_q[$];
    int     beat_cyc[$];
    int     X [8][8];
    int     WQ[8][8];
    int     WK[8][8];
    int     WV[8][8];
    longint expv[64];

    always @(posedge clk) cyc <= cyc + 1;

    // record every output beat and any valid overlap
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            beat_q.push_back(bus.out_data);
            beat_cyc.push_back(cyc);
        end
        if (bus.out_valid === 1'b1 && bus.in_valid === 1'b1) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.T        = 4'($urandom);
        bus.in_data  = 8'($urandom);
        bus.w_Q      = 8'($urandom);
        bus.w_K      = 8'($urandom);
        bus.w_V      = 8'($urandom);
    endtask

    task automatic fill(input int xv, input int qv, input int kv, input int vv);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                X[r][c] = xv; WQ[r][c] = qv; WK[r][c] = kv; WV[r][c] = vv;
            end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                X[r][c]  = int'($urandom_range(8, 0)) - 4;
                WQ[r][c] = int'($urandom_range(8, 0)) - 4;
                WK[r][c] = int'($urandom_range(8, 0)) - 4;
                WV[r][c] = int'($urandom_range(8, 0)) - 4;
            end
    endtask

    task automatic fill_exp(input longint v);
        for (int b = 0; b < 64; b++) expv[b] = v;
    endtask

    // straightforward matrix arithmetic in 64-bit integers
    task automatic build_model(input int t);
        longint q[8][8], k[8][8], v[8][8], sp[8][8], s;
        for (int i = 0; i < t; i++)
            for (int c = 0; c < 8; c++) begin
                q[i][c] = 0; k[i][c] = 0; v[i][c] = 0;
                for (int m = 0; m < 8; m++) begin
                    q[i][c] += longint'(X[i][m]) * WQ[m][c];
                    k[i][c] += longint'(X[i][m]) * WK[m][c];
                    v[i][c] += longint'(X[i][m]) * WV[m][c];
                end
            end
        for (int i = 0; i < t; i++)
            for (int kk = 0; kk < t; kk++) begin
                s = 0;
                for (int m = 0; m < 8; m++) s += q[i][m] * k[kk][m];
                sp[i][kk] = (s > 0) ? s / 3 : 0;
            end
        for (int i = 0; i < t; i++)
            for (int j = 0; j < 8; j++) begin
                expv[i*8+j] = 0;
                for (int kk = 0; kk < t; kk++) expv[i*8+j] += sp[i][kk] * v[kk][j];
            end
    endtask

    // drive one 192-cycle burst; abort_at >= 0 pulses reset at that burst cycle
    task automatic run_burst(input int t, input int abort_at);
        for (int c = 0; c < 192; c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                idle_inputs();
                @(posedge clk); #1;
                check("abort_rst_valid", 64'(bus.out_valid), 64'd0);
                rst_n = 1'b1;
                return;
            end
            bus.in_valid = 1'b1;
            bus.T        = (c == 0) ? 4'(t) : 4'($urandom);
            bus.in_data  = (c < 8*t) ? 8'(X[c/8][c%8]) : 8'($urandom);
            bus.w_Q      = (c < 64) ? 8'(WQ[c/8][c%8]) : 8'($urandom);
            bus.w_K      = (c >= 64 && c < 128) ? 8'(WK[(c-64)/8][c%8]) : 8'($urandom);
            bus.w_V      = (c >= 128) ? 8'(WV[(c-128)/8][c%8]) : 8'($urandom);
            @(posedge clk); #1;
        end
        idle_inputs();
        in_end_cyc = cyc;
    endtask

    // wait for 8t beats (bounded), then compare count, values, contiguity, latency
    task automatic collect(input int t, input string tag, input bit settle);
        int n = 8 * t;
        int waited = 0;
        int lat;
        while (beat_q.size() < n && waited < 1000) begin
            @(negedge clk); #1;
            waited++;
        end
        if (settle) begin
            repeat (4) @(negedge clk);
            #1;
        end
        check({tag, "_beats"}, 64'(beat_q.size()), 64'(n));
        for (int b = 0; b < n && b < beat_q.size(); b++)
            check($sformatf("%s_beat%0d", tag, b), beat_q[b], expv[b]);
        if (beat_q.size() >= n) begin
            check({tag, "_contig"}, 64'(beat_cyc[n-1] - beat_cyc[0]), 64'(n - 1));
            lat = beat_cyc[0] - in_end_cyc;
            check({tag, "_latency_ok"}, 64'(lat >= 1 && lat <= 600), 64'd1);
        end
        beat_q.delete();
        beat_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'bx;
        bus.T        = 'x;
        bus.in_data  = 'x;
        bus.w_Q      = 'x;
        bus.w_K      = 'x;
        bus.w_V      = 'x;
        @(posedge clk); #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", bus.out_data, 64'd0);
        rst_n = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;

        // T=1, all ones: S=512, S'=170, Out=170*8
        fill(1, 1, 1, 1);
        fill_exp(64'sd1360);
        run_burst(1, -1);
        collect(1, "t1_ones", 1'b1);

        // T=1, negative scores clamp to zero
        fill(1, 1, -1, 1);
        fill_exp(64'sd0);
        run_burst(1, -1);
        collect(1, "t1_neg", 1'b1);

        // T=8, extreme values: Out = 2^20 * floor(2^37/3)
        fill(-128, -128, -128, -128);
        fill_exp(64'sd48038396024586240);
        run_burst(8, -1);
        collect(8, "t8_max", 1'b1);

        // T=4 random pair, second burst two cycles after out_valid falls
        fill_rand();
        build_model(4);
        run_burst(4, -1);
        collect(4, "t4_a", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_gap_valid", 64'(bus.out_valid), 64'd0);
        fill_rand();
        build_model(4);
        run_burst(4, -1);
        collect(4, "t4_b", 1'b1);

        // reset at load counter 100, then a fresh T=8 burst
        fill_rand();
        run_burst(8, 100);
        repeat (20) @(posedge clk);
        #1;
        check("abort_quiet", 64'(beat_q.size()), 64'd0);
        fill_rand();
        build_model(8);
        run_burst(8, -1);
        collect(8, "t8_after_rst", 1'b1);

        check("no_overlap", 64'(overlap), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
